// File: rtl/puf_key_deriver.sv
// PUF-to-key derivation: majority-vote NUM_SAMPLES PUF responses, expand and mix into a KEY_W-bit key.
// Optional stability checking is enabled by defining PUFKEY_STAB_CHK_EN.
module puf_key_deriver #(
  parameter int PUF_W        = 16,
  parameter int KEY_W        = 128,
  parameter int NUM_SAMPLES  = 3,
  parameter int ROUNDS       = 5,
  parameter int ROT          = 7,
  parameter int UNSTABLE_MAX = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             puf_valid,
  output logic             puf_ready,
  input  logic [PUF_W-1:0] puf_data,
  output logic [KEY_W-1:0] key_out,
  output logic             key_valid,
  input  logic             key_ack,
  output logic             key_err,
  output logic             busy
);

  localparam int WORDS = KEY_W / PUF_W;
  localparam int CW    = $clog2(NUM_SAMPLES + 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_COLLECT = 3'd1,
    S_VOTE    = 3'd2,
    S_INIT    = 3'd3,
    S_MIX     = 3'd4,
    S_DONE    = 3'd5
`ifdef PUFKEY_STAB_CHK_EN
    , S_ERR   = 3'd6
`endif
  } state_t;

  function automatic logic [PUF_W-1:0] rotl_puf(input logic [PUF_W-1:0] x, input int n);
    logic [2*PUF_W-1:0] t;
    t = {x, x} << n;
    return t[2*PUF_W-1 -: PUF_W];
  endfunction

  function automatic logic [KEY_W-1:0] init_key(input logic [PUF_W-1:0] v);
    logic [KEY_W-1:0] k;
    logic [7:0]       pat;
    k = {KEY_W{1'b0}};
    for (int i = 0; i < WORDS; i++) begin
      pat = 8'hA5 ^ 8'(i);
      k[i*PUF_W +: PUF_W] = rotl_puf(v, i % PUF_W) ^ {(PUF_W/8){pat}};
    end
    return k;
  endfunction

  function automatic logic [KEY_W-1:0] mix_round(input logic [KEY_W-1:0] k,
                                                 input logic [PUF_W-1:0] v,
                                                 input logic [3:0]       r);
    return {k[KEY_W-ROT-1:0], k[KEY_W-1:KEY_W-ROT]} ^ (k >> (KEY_W/2)) ^
           {WORDS{v}} ^ {(KEY_W/8){{4'h0, r}}};
  endfunction

`ifdef PUFKEY_STAB_CHK_EN
  function automatic logic [7:0] popcount(input logic [PUF_W-1:0] x);
    logic [7:0] c;
    c = 8'd0;
    for (int b = 0; b < PUF_W; b++) begin
      c = c + 8'(x[b]);
    end
    return c;
  endfunction
`endif

  state_t           state_r;
  logic [CW-1:0]    cnt_r [PUF_W];
  logic [CW-1:0]    smp_cnt_r;
  logic [PUF_W-1:0] vote_r;
  logic [KEY_W-1:0] key_r;
  logic [3:0]       round_r;
  logic             puf_ready_r;
  logic             key_valid_r;
  logic [KEY_W-1:0] key_out_r;
  logic             busy_r;
  logic [PUF_W-1:0] vote_s;
  logic [KEY_W-1:0] init_key_s;
  logic [KEY_W-1:0] mix_key_s;
`ifdef PUFKEY_STAB_CHK_EN
  logic [PUF_W-1:0] and_all_r;
  logic [PUF_W-1:0] or_all_r;
  logic             key_err_r;
  logic [7:0]       unstable_s;
  assign unstable_s = popcount(or_all_r ^ and_all_r);
  assign key_err    = key_err_r;
`else
  assign key_err    = 1'b0;
`endif

  // Bitwise majority of the collected samples
  always_comb begin
    vote_s = {PUF_W{1'b0}};
    for (int b = 0; b < PUF_W; b++) begin
      vote_s[b] = (cnt_r[b] > CW'(NUM_SAMPLES / 2));
    end
  end

  assign init_key_s = init_key(vote_r);
  assign mix_key_s  = mix_round(key_r, vote_r, round_r);

  assign puf_ready = puf_ready_r;
  assign key_valid = key_valid_r;
  assign key_out   = key_out_r;
  assign busy      = busy_r;

  // Control FSM with all datapath state and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= S_IDLE;
      smp_cnt_r   <= {CW{1'b0}};
      vote_r      <= {PUF_W{1'b0}};
      key_r       <= {KEY_W{1'b0}};
      round_r     <= 4'd0;
      puf_ready_r <= 1'b0;
      key_valid_r <= 1'b0;
      key_out_r   <= {KEY_W{1'b0}};
      busy_r      <= 1'b0;
      for (int b = 0; b < PUF_W; b++) begin
        cnt_r[b] <= {CW{1'b0}};
      end
`ifdef PUFKEY_STAB_CHK_EN
      and_all_r   <= {PUF_W{1'b0}};
      or_all_r    <= {PUF_W{1'b0}};
      key_err_r   <= 1'b0;
`endif
    end else begin
      case (state_r)
        S_IDLE: begin
          if (start) begin
            state_r     <= S_COLLECT;
            puf_ready_r <= 1'b1;
            busy_r      <= 1'b1;
            smp_cnt_r   <= {CW{1'b0}};
`ifdef PUFKEY_STAB_CHK_EN
            and_all_r   <= {PUF_W{1'b1}};
            or_all_r    <= {PUF_W{1'b0}};
`endif
          end
        end
        S_COLLECT: begin
          if (puf_valid && puf_ready_r) begin
            for (int b = 0; b < PUF_W; b++) begin
              cnt_r[b] <= cnt_r[b] + CW'(puf_data[b]);
            end
`ifdef PUFKEY_STAB_CHK_EN
            and_all_r <= and_all_r & puf_data;
            or_all_r  <= or_all_r | puf_data;
`endif
            if (smp_cnt_r == CW'(NUM_SAMPLES - 1)) begin
              state_r     <= S_VOTE;
              puf_ready_r <= 1'b0;
              smp_cnt_r   <= {CW{1'b0}};
            end else begin
              smp_cnt_r <= smp_cnt_r + CW'(1);
            end
          end
        end
        S_VOTE: begin
          for (int b = 0; b < PUF_W; b++) begin
            cnt_r[b] <= {CW{1'b0}};
          end
`ifdef PUFKEY_STAB_CHK_EN
          if (unstable_s > 8'(UNSTABLE_MAX)) begin
            state_r   <= S_ERR;
            key_err_r <= 1'b1;
            vote_r    <= {PUF_W{1'b0}};
            key_r     <= {KEY_W{1'b0}};
          end else begin
            state_r <= S_INIT;
            vote_r  <= vote_s;
          end
`else
          state_r <= S_INIT;
          vote_r  <= vote_s;
`endif
        end
        S_INIT: begin
          key_r   <= init_key_s;
          round_r <= 4'd0;
          state_r <= S_MIX;
        end
        S_MIX: begin
          key_r <= mix_key_s;
          // The final round is presented on key_out at the same edge it is computed
          if (round_r == 4'(ROUNDS - 1)) begin
            key_out_r   <= mix_key_s;
            key_valid_r <= 1'b1;
            round_r     <= 4'd0;
            state_r     <= S_DONE;
          end else begin
            round_r <= round_r + 4'd1;
          end
        end
        S_DONE: begin
          if (key_ack) begin
            key_out_r   <= {KEY_W{1'b0}};
            key_valid_r <= 1'b0;
            key_r       <= {KEY_W{1'b0}};
            vote_r      <= {PUF_W{1'b0}};
            busy_r      <= 1'b0;
            state_r     <= S_IDLE;
          end
        end
`ifdef PUFKEY_STAB_CHK_EN
        S_ERR: begin
          if (key_ack) begin
            key_err_r <= 1'b0;
            busy_r    <= 1'b0;
            state_r   <= S_IDLE;
          end
        end
`endif
        default: begin
          state_r     <= S_IDLE;
          puf_ready_r <= 1'b0;
          key_valid_r <= 1'b0;
          key_out_r   <= {KEY_W{1'b0}};
          key_r       <= {KEY_W{1'b0}};
          vote_r      <= {PUF_W{1'b0}};
          busy_r      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_puf_key_deriver.sv
// Scoreboard bench for puf_key_deriver: the driver queues expected keys, a monitor checks each key_valid rise.
module tb_puf_key_deriver;
  localparam int PW = 16;
  localparam int KW = 128;
  localparam int RD = 5;
  localparam int RT = 7;

  logic          clk = 1'b0;
  logic          rst, start, puf_valid, key_ack;
  logic [PW-1:0] puf_data;
  logic          puf_ready, key_valid, key_err, busy;
  logic [KW-1:0] key_out;

  logic          start1, puf_valid1, key_ack1;
  logic [PW-1:0] puf_data1;
  logic          puf_ready1, key_valid1, key_err1, busy1;
  logic [KW-1:0] key_out1;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    logic [KW-1:0] key;
    int            at;
  } exp_t;
  exp_t exp_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  puf_key_deriver #(.PUF_W(PW), .KEY_W(KW), .NUM_SAMPLES(3), .ROUNDS(RD), .ROT(RT),
                    .UNSTABLE_MAX(16)) dut (
    .clk(clk), .rst(rst), .start(start), .puf_valid(puf_valid), .puf_ready(puf_ready),
    .puf_data(puf_data), .key_out(key_out), .key_valid(key_valid), .key_ack(key_ack),
    .key_err(key_err), .busy(busy));

  puf_key_deriver #(.PUF_W(PW), .KEY_W(KW), .NUM_SAMPLES(1), .ROUNDS(RD), .ROT(RT)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .puf_valid(puf_valid1), .puf_ready(puf_ready1),
    .puf_data(puf_data1), .key_out(key_out1), .key_valid(key_valid1), .key_ack(key_ack1),
    .key_err(key_err1), .busy(busy1));

`ifdef PUFKEY_STAB_CHK_EN
  logic          start2, puf_valid2, key_ack2;
  logic [PW-1:0] puf_data2;
  logic          puf_ready2, key_valid2, key_err2, busy2;
  logic [KW-1:0] key_out2;
  puf_key_deriver #(.PUF_W(PW), .KEY_W(KW), .NUM_SAMPLES(3), .ROUNDS(RD), .ROT(RT),
                    .UNSTABLE_MAX(4)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .puf_valid(puf_valid2), .puf_ready(puf_ready2),
    .puf_data(puf_data2), .key_out(key_out2), .key_valid(key_valid2), .key_ack(key_ack2),
    .key_err(key_err2), .busy(busy2));
`endif

  // Bit-level reference of the INIT expansion followed by RD mix rounds
  function automatic logic [KW-1:0] model_key(input logic [PW-1:0] v);
    logic [KW-1:0] k, nk;
    logic [7:0]    pat, rb;
    for (int i = 0; i < KW/PW; i++) begin
      pat = 8'hA5 ^ 8'(i);
      for (int j = 0; j < PW; j++) k[i*PW+j] = v[(j - (i % PW) + PW) % PW] ^ pat[j % 8];
    end
    for (int r = 0; r < RD; r++) begin
      rb = 8'(r);
      for (int b = 0; b < KW; b++)
        nk[b] = k[(b - RT + KW) % KW] ^ ((b + KW/2 < KW) ? k[b + KW/2] : 1'b0) ^ v[b % PW] ^ rb[b % 8];
      k = nk;
    end
    return k;
  endfunction

  task automatic check(input string name, input logic [KW-1:0] act, input logic [KW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: compare each new key against the scoreboard, and key_out must be 0 when not valid
  logic prev_valid = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (key_valid === 1'b1 && prev_valid !== 1'b1) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_key: got %h want none", key_out);
      end else begin
        e = exp_q.pop_front();
        check("key_value", key_out, e.key);
        check("key_latency", KW'(cyc), KW'(e.at));
      end
    end
    if (key_valid === 1'b0) check("key_zero_when_invalid", key_out, '0);
    prev_valid = key_valid;
  end

  task automatic send(input logic [PW-1:0] d, input int gap, output int e);
    int n;
    n = 0;
    for (int g = 0; g < gap; g++) begin
      tick();
      check("ready_in_gap", KW'(puf_ready), KW'(1));
    end
    puf_valid = 1'b1;
    puf_data  = d;
    while (puf_ready !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    if (puf_ready !== 1'b1) begin
      total++;
      bad++;
      $display("FAIL ready_timeout: got %b want 1", puf_ready);
    end
    tick();
    e = cyc;
    puf_valid = 1'b0;
  endtask

  task automatic launch();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic feed(input logic [PW-1:0] s0, s1, s2, input int gap, input logic [PW-1:0] v);
    int e;
    send(s0, 0, e);
    send(s1, gap, e);
    send(s2, gap, e);
    exp_q.push_back('{key: model_key(v), at: e + RD + 2});
  endtask

  task automatic wait_valid();
    int n;
    n = 0;
    while (key_valid !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    if (key_valid !== 1'b1) begin
      total++;
      bad++;
      $display("FAIL valid_timeout: got %b want 1", key_valid);
    end
  endtask

  task automatic ack();
    key_ack = 1'b1;
    tick();
    key_ack = 1'b0;
  endtask

  task automatic check_idle(input string name);
    check({name, "_busy"}, KW'(busy), KW'(0));
    check({name, "_valid"}, KW'(key_valid), KW'(0));
    check({name, "_ready"}, KW'(puf_ready), KW'(0));
    check({name, "_key"}, key_out, '0);
    check({name, "_err"}, KW'(key_err), KW'(0));
  endtask

  initial begin
    int e;
    int n;
    rst = 1'b1; start = 1'b0; puf_valid = 1'b0; key_ack = 1'b0; puf_data = '0;
    start1 = 1'b0; puf_valid1 = 1'b0; key_ack1 = 1'b0; puf_data1 = '0;
`ifdef PUFKEY_STAB_CHK_EN
    start2 = 1'b0; puf_valid2 = 1'b0; key_ack2 = 1'b0; puf_data2 = '0;
`endif
    repeat (3) tick();
    check_idle("reset");
    rst = 1'b0;
    tick();

    // Majority vote and latency
    launch();
    feed(16'h1234, 16'h1234, 16'hFFFF, 0, 16'h1234);
    wait_valid();
    check("busy_done", KW'(busy), KW'(1));
    repeat (3) tick();
    check("key_held", key_out, model_key(16'h1234));
    check("valid_held", KW'(key_valid), KW'(1));
    ack();
    check_idle("after_ack");

    // Ack in IDLE has no effect
    key_ack = 1'b1;
    tick();
    key_ack = 1'b0;
    tick();
    check_idle("ack_in_idle");

    // Backpressure gaps between samples
    launch();
    feed(16'h1234, 16'h1234, 16'hFFFF, 2, 16'h1234);
    wait_valid();
    ack();

    // Second vote pattern
    launch();
    feed(16'hF0F0, 16'h0FF0, 16'h00FF, 0, 16'h00F0);
    wait_valid();
    ack();

    // Reset during round 2 aborts, fresh start accepted afterwards
    launch();
    send(16'h1111, 0, e);
    send(16'h2222, 0, e);
    send(16'h3333, 0, e);
    repeat (4) tick();
    rst = 1'b1;
    tick();
    check_idle("reset_mid_mix");
    rst = 1'b0;
    launch();
    check("restart_ready", KW'(puf_ready), KW'(1));
    check("restart_busy", KW'(busy), KW'(1));
    feed(16'hBEEF, 16'hBEEF, 16'h0000, 0, 16'hBEEF);
    wait_valid();
    ack();

    // Start pulses while busy are ignored
    launch();
    send(16'h1234, 0, e);
    start = 1'b1;
    send(16'h1234, 0, e);
    start = 1'b0;
    send(16'hFFFF, 0, e);
    exp_q.push_back('{key: model_key(16'h1234), at: e + RD + 2});
    repeat (3) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_valid();

    // Start held high across ack relaunches from IDLE
    start = 1'b1;
    ack();
    check("idle_between", KW'(busy), KW'(0));
    tick();
    start = 1'b0;
    check("relaunch_busy", KW'(busy), KW'(1));
    check("relaunch_ready", KW'(puf_ready), KW'(1));
    feed(16'h5A5A, 16'hFFFF, 16'h5A5A, 0, 16'h5A5A);
    wait_valid();
    ack();

    // Single-sample instance passes the sample straight through the vote
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    puf_valid1 = 1'b1;
    puf_data1  = 16'hA5C3;
    tick();
    e = cyc;
    puf_valid1 = 1'b0;
    n = 0;
    while (key_valid1 !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    check("ns1_valid", KW'(key_valid1), KW'(1));
    check("ns1_latency", KW'(cyc), KW'(e + RD + 2));
    check("ns1_key", key_out1, model_key(16'hA5C3));
    key_ack1 = 1'b1;
    tick();
    key_ack1 = 1'b0;
    check("ns1_after_ack", KW'(busy1), KW'(0));

`ifdef PUFKEY_STAB_CHK_EN
    // Unstable samples raise key_err and never produce a key
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    puf_valid2 = 1'b1;
    puf_data2 = 16'h0000; tick();
    puf_data2 = 16'hFFFF; tick();
    puf_data2 = 16'h0000; tick();
    puf_valid2 = 1'b0;
    repeat (10) tick();
    check("stab_err", KW'(key_err2), KW'(1));
    check("stab_valid", KW'(key_valid2), KW'(0));
    check("stab_key", key_out2, '0);
    check("stab_busy", KW'(busy2), KW'(1));
    key_ack2 = 1'b1;
    tick();
    key_ack2 = 1'b0;
    check("stab_err_clear", KW'(key_err2), KW'(0));
    check("stab_idle", KW'(busy2), KW'(0));
`endif

    repeat (3) tick();
    check("queue_drained", KW'(exp_q.size()), KW'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
